seq_restoring_divider: RTL and testbench

// - Sequential unsigned restoring divider: computes dividend / divisor, one quotient bit per clock.
// - Inverse operation of the 8-bit Wallace-tree multiplier; shares its operand width.
// - Sits beside the multiplier in the arithmetic datapath, with a start/busy/done handshake.
// - Result is checkable by round trip: quotient * divisor + remainder == dividend.
//

---
 rtl/arith_pkg.sv | 14 +
 rtl/seq_restoring_divider_sub_row.sv | 30 +++
 rtl/seq_restoring_divider.sv | 133 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
// - ARITH_WIDTH : default operand width, common to the Wallace multiplier and the divider
// - div_state_t : divider FSM state encoding (IDLE, RUN, DONE) in 2 bits
package arith_pkg;

    localparam int ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_sub_row.sv
// sub_row: N-bit ripple subtractor built from full-subtractor cells.
// Ports:
// - a    in  N  minuend
// - b    in  N  subtrahend
// - diff out N  a - b (modulo 2^N)
// - bout out 1  final borrow; 1 when a < b
module sub_row #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         bout
);

    // borrow[0] is the (zero) borrow into the LSB cell.
    logic [N:0] borrow;

    assign borrow[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cell
            assign diff[gi]       = a[gi] ^ b[gi] ^ borrow[gi];
            assign borrow[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow[gi]);
        end
    endgenerate

    assign bout = borrow[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: sequential unsigned restoring divider, one quotient bit
// per clock, start/busy/done handshake.
// Ports:
// - clk, rst              clock, synchronous active-high reset
// - start                 request a division (accepted only in IDLE)
// - dividend, divisor     operands, captured when start is accepted
// - busy                  high while iterating
// - done                  one-cycle pulse, results valid
// - quotient, remainder   registered results, held until the next completion
// - div_by_zero           set with done when the captured divisor was zero
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    div_state_t       state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] a_reg;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] p_reg;      // partial remainder
    logic [WIDTH-1:0] dvs_reg;    // captured divisor
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;

    // P stays below the divisor after every step, so it fits in WIDTH bits;
    // only the shifted value P' needs the extra bit.
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             keep;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] a_next;

    assign p_shift = {p_reg, a_reg[WIDTH-1]};

    sub_row #(
        .N(WIDTH + 1)
    ) u_sub_row (
        .a    (p_shift),
        .b    ({1'b0, dvs_reg}),
        .diff (diff),
        .bout (borrow)
    );

    // With P' < 2*divisor a non-borrowing difference always has a clear
    // MSB, so both indicators agree; keep only when neither says negative.
    assign keep   = ~borrow & ~diff[WIDTH];
    assign p_next = keep ? diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
    assign a_next = {a_reg[WIDTH-2:0], keep};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            a_reg         <= '0;
            p_reg         <= '0;
            dvs_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        dvs_reg   <= divisor;
                        a_reg     <= dividend;
                        p_reg     <= '0;
                        count_reg <= '0;
                        if (divisor == '0) begin
                            // Skip iteration entirely; result is defined directly.
                            state_reg     <= DONE;
                            done_reg      <= 1'b1;
                            quotient_reg  <= '1;
                            remainder_reg <= dividend;
                            dbz_reg       <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    a_reg     <= a_next;
                    p_reg     <= p_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST) begin
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        quotient_reg  <= a_next;
                        remainder_reg <= p_next;
                        dbz_reg       <= 1'b0;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int unsigned  at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d: q=%0d r=%0d dbz=%0d",
                         cyc, quotient, remainder, div_by_zero);
            end else begin
                e = sb.pop_front();
                $display("done @%0d: q=%0d r=%0d dbz=%0d (expected q=%0d r=%0d dbz=%0d @%0d)",
                         cyc, quotient, remainder, div_by_zero, e.q, e.r, e.z, e.at);
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", div_by_zero, e.z);
                check("done_latency_cycle", cyc, e.at);
                check("busy_low_at_done", busy, 0);
            end
        end
    end

    // Drive one start pulse; when push is set, queue the expected result.
    task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d, input bit push,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        exp_t e;
        @(negedge clk);
        dividend = n;
        divisor  = d;
        start    = 1'b1;
        if (push) begin
            e.q  = eq;
            e.r  = er;
            e.z  = ez;
            e.at = cyc + 1 + ((d == '0) ? 0 : W);
            sb.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        // Scramble the inputs so only the captured copies can produce the result.
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [W-1:0] n, input logic [W-1:0] d,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        issue(n, d, 1'b1, eq, er, ez);
        drain();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_quotient"}, quotient, 0);
        check({tag, "_remainder"}, remainder, 0);
        check({tag, "_div_by_zero"}, div_by_zero, 0);
    endtask

    initial begin
        logic [W-1:0] n;
        logic [W-1:0] d;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        run(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        run(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        run(8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
        run(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1);
        run(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);

        // start pulsed during RUN cycle 3 must be ignored: one done only.
        issue(8'd100, 8'd10, 1'b1, 8'd10, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("busy_in_run", busy, 1);
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);

        // Reset at RUN cycle 4 aborts: no done, outputs cleared.
        issue(8'd180, 8'd11, 1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        repeat (12) @(negedge clk);
        run(8'd180, 8'd11, 8'd16, 8'd4, 1'b0);

        for (int i = 0; i < 30; i++) begin
            n = W'($urandom_range(0, 255));
            d = W'($urandom_range(1, 255));
            run(n, d, n / d, n % d, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
